// File: rtl/blink_pkg.sv
// Shared constants and types for the LED blink speed controller.
// Half-period lengths are counted in base ticks; each level halves the blink period.
package blink_pkg;

  localparam int unsigned HP_L0 = 500;
  localparam int unsigned HP_L1 = 250;
  localparam int unsigned HP_L2 = 125;
  localparam int unsigned HP_L3 = 63;

  localparam int unsigned CNT_W = 9;

  typedef logic [1:0]       level_t;
  typedef logic [CNT_W-1:0] hp_cnt_t;

  localparam level_t LEVEL_MIN = 2'd0;
  localparam level_t LEVEL_MAX = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  // Terminal value of the half-period counter for a given speed level.
  function automatic hp_cnt_t hp_last(input level_t lvl);
    hp_cnt_t last;
    case (lvl)
      2'd0:    last = hp_cnt_t'(HP_L0 - 1);
      2'd1:    last = hp_cnt_t'(HP_L1 - 1);
      2'd2:    last = hp_cnt_t'(HP_L2 - 1);
      default: last = hp_cnt_t'(HP_L3 - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/blink_speed_ctrl_if.sv
// Button pulses in, LED/level/run status out, bundled between the debouncers
// (master side) and the blink controller (slave side).
interface blink_speed_ctrl_if;
  import blink_pkg::*;

  logic   BTN_UP;
  logic   BTN_DN;
  logic   BTN_PAUSE;
  logic   LED;
  level_t LEVEL;
  logic   RUN;

  modport master (
    output BTN_UP, BTN_DN, BTN_PAUSE,
    input  LED, LEVEL, RUN
  );

  modport slave (
    input  BTN_UP, BTN_DN, BTN_PAUSE,
    output LED, LEVEL, RUN
  );

endinterface

// File: rtl/blink_speed_ctrl_tick_gen.sv
// Base tick prescaler: counts 0..TICK_DIV-1 and strobes TICK on the last count.
// EN=0 freezes the count (phase is kept); CLR restarts the period and wins over EN.
module tick_gen #(
  parameter int unsigned TICK_DIV = 125000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  // Prescaler count: clear, hold, or advance with wrap at the last count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (EN) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign TICK = (count == LAST);

endmodule

// File: rtl/blink_speed_ctrl.sv
// LED blink controller: run/pause FSM, saturating 4-level speed register,
// half-period counter on top of a 1 ms prescaler, and the registered LED.
// A level change restarts the half-period so the new rate takes effect cleanly.
module blink_speed_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned TICK_DIV = 125000
) (
  input  logic               CLK,
  input  logic               RST,
  blink_speed_ctrl_if.slave  bus
);

  state_t  state;
  state_t  state_next;
  level_t  level;
  level_t  level_next;
  logic    level_chg;
  hp_cnt_t hp_cnt;
  logic    led;
  logic    run;
  logic    tick;
  logic    tick_run;
  logic    terminal;

  assign run = (state == ST_RUN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (run),
    .CLR  (level_chg),
    .TICK (tick)
  );

  // The prescaler can sit on its last count while paused, so gate the strobe.
  assign tick_run = tick & run;
  assign terminal = tick_run && (hp_cnt == hp_last(level));

  // Level request: opposing presses cancel, saturated presses are no-ops.
  always_comb begin
    level_next = level;
    if (bus.BTN_UP && !bus.BTN_DN && (level != LEVEL_MAX)) begin
      level_next = level + 2'd1;
    end else if (bus.BTN_DN && !bus.BTN_UP && (level != LEVEL_MIN)) begin
      level_next = level - 2'd1;
    end
    level_chg = (level_next != level);
  end

  // Run/pause next-state: each pause pulse flips the state.
  always_comb begin
    state_next = state;
    if (bus.BTN_PAUSE) begin
      case (state)
        ST_RUN:    state_next = ST_PAUSED;
        ST_PAUSED: state_next = ST_RUN;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  // State and speed level registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_RUN;
      level <= LEVEL_MIN;
    end else begin
      state <= state_next;
      level <= level_next;
    end
  end

  // Half-period counter: a level change restarts it, otherwise it advances on running ticks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hp_cnt <= '0;
    end else if (level_chg) begin
      hp_cnt <= '0;
    end else if (tick_run) begin
      hp_cnt <= terminal ? '0 : hp_cnt + 1'b1;
    end
  end

  // LED toggles at terminal count unless a level change lands in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led <= 1'b0;
    end else if (terminal && !level_chg) begin
      led <= ~led;
    end
  end

  assign bus.LED   = led;
  assign bus.LEVEL = level;
  assign bus.RUN   = run;

endmodule

// File: tb/tb_blink_speed_ctrl.sv
// Bench for blink_speed_ctrl with TICK_DIV=4 (level 0 half-period = 2000 cycles).
module tb_blink_speed_ctrl;

  localparam int unsigned TD = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  blink_speed_ctrl_if bus ();

  blink_speed_ctrl #(
    .TICK_DIV (TD)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       up;
    logic       dn;
    logic       pause;
    logic [1:0] exp_level;
    logic       exp_run;
  } vec_t;

  typedef struct {
    int level;
    int run;
  } lr_t;

  vec_t vecs [7];
  lr_t  exp_q [$];
  int   tog_q [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tog = 0;
  logic led_prev = 1'b0;

  int   m_level;
  int   m_rem;
  bit   m_run;
  bit   m_led;

  function automatic int hp_of(input int l);
    case (l)
      0:       return 500;
      1:       return 250;
      2:       return 125;
      default: return 63;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_run   = 1'b1;
    m_led   = 1'b0;
    m_rem   = 500 * TD;
    tog_q.delete();
    exp_q.delete();
  endtask

  // Reference: countdown of edges left until the next toggle.
  task automatic model_edge(input bit up, input bit dn, input bit pause);
    int nl;
    lr_t e;
    nl = m_level;
    if (up && !dn && m_level < 3) nl = m_level + 1;
    else if (dn && !up && m_level > 0) nl = m_level - 1;
    if (nl != m_level) begin
      m_level = nl;
      m_rem   = hp_of(nl) * TD;
    end else if (m_run) begin
      m_rem--;
      if (m_rem == 0) begin
        m_led = ~m_led;
        tog_q.push_back(cyc);
        m_rem = hp_of(m_level) * TD;
      end
    end
    if (pause) m_run = ~m_run;
    if (up || dn || pause) begin
      e.level = m_level;
      e.run   = m_run ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit up, input bit dn, input bit pause);
    lr_t e;
    int  stamp;
    bus.BTN_UP    = up;
    bus.BTN_DN    = dn;
    bus.BTN_PAUSE = pause;
    @(posedge CLK);
    cyc++;
    if (RST) model_edge(up, dn, pause);
    #1;
    bus.BTN_UP    = 1'b0;
    bus.BTN_DN    = 1'b0;
    bus.BTN_PAUSE = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_level", int'(bus.LEVEL), e.level);
      chk("sb_run", int'(bus.RUN), e.run);
    end
    if (bus.LED !== led_prev) begin
      last_tog = cyc;
      if (tog_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_toggle actual=toggle_at_%0d expected=no_toggle", cyc);
      end else begin
        stamp = tog_q.pop_front();
        chk("sb_toggle_cycle", cyc, stamp);
      end
      led_prev = bus.LED;
    end else if (tog_q.size() > 0 && tog_q[0] <= cyc) begin
      stamp = tog_q.pop_front();
      chk("sb_missing_toggle", -1, stamp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_toggle(input int budget);
    int start;
    int k;
    start = last_tog;
    k = 0;
    while (last_tog == start && k < budget) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    if (last_tog == start) chk("toggle_timeout", 0, 1);
  endtask

  initial begin
    int   t0;
    int   t_chg;
    int   t_btn;
    int   t_res;
    int   prev_lvl;
    int   tog_before;
    logic led_hold;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1};

    bus.BTN_UP    = 1'b0;
    bus.BTN_DN    = 1'b0;
    bus.BTN_PAUSE = 1'b0;
    model_reset();
    t_chg = 0;
    t_btn = 0;

    // Reset state
    idle(3);
    chk("reset_led", int'(bus.LED), 0);
    chk("reset_level", int'(bus.LEVEL), 0);
    chk("reset_run", int'(bus.RUN), 1);

    // 1: reset then run
    RST = 1'b1;
    model_reset();
    t0 = cyc;
    wait_toggle(3000);
    chk("t1_rise_after_release", last_tog - t0, 2000);
    chk("t1_led_high", int'(bus.LED), 1);
    t0 = last_tog;
    wait_toggle(3000);
    chk("t1_fall_interval", last_tog - t0, 2000);
    chk("t1_led_low", int'(bus.LED), 0);
    chk("t1_level", int'(bus.LEVEL), 0);
    chk("t1_run", int'(bus.RUN), 1);

    // 2: level up with saturation
    for (int i = 0; i < 4; i++) begin
      prev_lvl = int'(bus.LEVEL);
      step(vecs[i].up, vecs[i].dn, vecs[i].pause);
      if (int'(vecs[i].exp_level) != prev_lvl) t_chg = cyc;
      chk("tbl_level", int'(bus.LEVEL), int'(vecs[i].exp_level));
      chk("tbl_run", int'(bus.RUN), int'(vecs[i].exp_run));
      idle(9);
    end
    wait_toggle(400);
    chk("t2_l3_first_toggle", last_tog - t_chg, 252);
    t0 = last_tog;
    wait_toggle(400);
    chk("t2_l3_interval", last_tog - t0, 252);

    // Mixed presses: down+pause together, cancelled pair while paused, resume
    for (int i = 4; i < 7; i++) begin
      step(vecs[i].up, vecs[i].dn, vecs[i].pause);
      t_btn = cyc;
      chk("tbl_level", int'(bus.LEVEL), int'(vecs[i].exp_level));
      chk("tbl_run", int'(bus.RUN), int'(vecs[i].exp_run));
      idle(9);
    end
    wait_toggle(1000);
    chk("t3_l2_after_resume", last_tog - t_btn, 500);

    // 3: simultaneous up/down at level 2
    t0 = last_tog;
    idle(100);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_simul_level", int'(bus.LEVEL), 2);
    wait_toggle(1000);
    chk("t3_phase_kept", last_tog - t0, 500);

    // 4: pause and resume at level 1
    step(1'b0, 1'b1, 1'b0);
    t_chg = cyc;
    chk("t4_level", int'(bus.LEVEL), 1);
    wait_toggle(1500);
    chk("t4_half_period", last_tog - t_chg, 1000);
    idle(99);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_paused", int'(bus.RUN), 0);
    led_hold   = bus.LED;
    tog_before = last_tog;
    idle(5000);
    chk("t4_led_held", int'(bus.LED), int'(led_hold));
    chk("t4_no_toggle_paused", last_tog, tog_before);
    step(1'b0, 1'b0, 1'b1);
    t_res = cyc;
    chk("t4_resumed", int'(bus.RUN), 1);
    wait_toggle(1500);
    chk("t4_remaining_after_resume", last_tog - t_res, 900);

    // 5: level change in the terminal-count cycle
    idle(999);
    led_hold = bus.LED;
    step(1'b0, 1'b1, 1'b0);
    t_chg = cyc;
    chk("t5_no_toggle", int'(bus.LED), int'(led_hold));
    chk("t5_level", int'(bus.LEVEL), 0);
    wait_toggle(2500);
    chk("t5_next_toggle", last_tog - t_chg, 2000);

    // 6: async reset while paused at level 3
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    chk("t6_level3", int'(bus.LEVEL), 3);
    wait_toggle(300);
    if (bus.LED == 1'b0) wait_toggle(300);
    chk("t6_led_high_before", int'(bus.LED), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("t6_paused", int'(bus.RUN), 0);
    idle(20);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_async_led", int'(bus.LED), 0);
    chk("t6_async_level", int'(bus.LEVEL), 0);
    chk("t6_async_run", int'(bus.RUN), 1);
    model_reset();
    led_prev = bus.LED;
    idle(3);
    RST = 1'b1;
    model_reset();
    t0 = cyc;
    wait_toggle(2500);
    chk("t6_first_after_release", last_tog - t0, 2000);
    chk("sb_pending_toggles", tog_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_speed_ctrl.md
# blink_speed_ctrl

Sequences the LED blink datapath from debounced button pulses. It owns a 1 ms tick prescaler, a 4-level speed register and a half-period counter, and it drives one LED output. It sits directly after the per-button debouncers, which deliver one-cycle rising-edge pulses, and before the board LED pin. A run/pause state machine freezes or resumes blinking without losing phase.

## Interface
- `TICK_DIV`, default 125000: CLK cycles per base tick (1 ms at 125 MHz). Must be ≥ 2.
- `CLK` in, 1 bit: single clock, rising edge.
- `RST` in, 1 bit: reset, asynchronous, active-low.
- `BTN_UP` in, 1 bit: one-cycle pulse; speed level +1.
- `BTN_DN` in, 1 bit: one-cycle pulse; speed level −1.
- `BTN_PAUSE` in, 1 bit: one-cycle pulse; toggles run/pause.
- `LED` out, 1 bit: blink output, registered.
- `LEVEL` out, 2 bits: current speed level, registered.
- `RUN` out, 1 bit: 1 = RUN state, 0 = PAUSED.

## Operation
- Reset (`RST`=0, async): `LED`=0, `LEVEL`=0, `RUN`=1, state RUN, prescaler=0, half-period counter=0.
- Prescaler counts 0..`TICK_DIV`−1 and wraps.
- `tick` is a combinational strobe, asserted when the count equals `TICK_DIV`−1.
- Half-period lengths in ticks come from the package: level 0 = 500, 1 = 250, 2 = 125, 3 = 63.
- Half-period counter is 9 bits wide and unsigned. It increments on `tick` when in RUN.
  - When it equals HP[`LEVEL`]−1 and `tick` is high: counter ← 0 and `LED` ← ~`LED`.
- State machine:
  - RUN → PAUSED on `BTN_PAUSE`.
  - PAUSED → RUN on `BTN_PAUSE`.
  - In PAUSED, the prescaler and half-period counter hold, and `LED` holds its value.
- Level change:
  - `BTN_UP` saturates at 3. `BTN_DN` saturates at 0.
  - Level changes are accepted in both states.
  - An accepted change that actually alters `LEVEL` clears the half-period counter and the prescaler. The next toggle therefore occurs exactly HP[new]×`TICK_DIV` cycles later (in RUN).
  - A saturated press (no change) leaves the counters untouched.
- Simultaneous `BTN_UP` and `BTN_DN` in the same cycle: both are ignored and nothing changes.
- `BTN_PAUSE` in the same cycle as `BTN_UP` or `BTN_DN`: both are applied independently.
- Level change and terminal count in the same cycle: the level change wins. The counter clears and `LED` does not toggle.
- Pulses held high for multiple cycles count once per cycle. Inputs are assumed to be already synchronized one-cycle pulses.

## Timing
- Button pulse sampled at edge n → `LEVEL` and `RUN` are updated after edge n, visible in cycle n+1. One cycle of latency.
- Terminal count (tick and counter = HP−1) sampled at edge n → `LED` changes after edge n.
- Full blink period = 2×HP[`LEVEL`]×`TICK_DIV` cycles: 1.0 s, 0.5 s, 0.25 s and 0.126 s at level 0 to 3.
- Reset mid-period forces the reset values immediately (async) and releases synchronously on the next edge.
  - The first toggle after release occurs 500×`TICK_DIV` cycles later.
- Pausing mid-period preserves the prescaler and counter values. Resume continues from the frozen values, so the remaining time is exact.

## Structure
- Package `blink_pkg`:
  - Half-period constants `HP_L0..HP_L3`.
  - Level type (2 bits).
  - State encoding for `ST_RUN` and `ST_PAUSED`.
  - Counter width constant (9).
- Sub-module `tick_gen`, parameterised by `TICK_DIV`.
  - Ports: `CLK`, `RST`, `EN` (hold when 0), `CLR` (sync clear) and `TICK` out.
  - It is reused by other timed blocks.
- Top `blink_speed_ctrl` contains the FSM, level register, half-period counter and LED register.

## Test plan
Simulate with `TICK_DIV`=4, so level 0 gives a half-period of 2000 cycles.
1. **Reset then run:** release `RST`, idle → `LED` rises at cycle 2000 and falls at 4000; `LEVEL`=0, `RUN`=1.
2. **Level up and saturation:** 4× `BTN_UP` pulses spaced 10 cycles apart → `LEVEL` steps 1, 2, 3, 3. After the last change the toggle interval is 63×4 = 252 cycles. The fourth press leaves the counter phase unchanged.
3. **Simultaneous buttons:** `BTN_UP` and `BTN_DN` in the same cycle at level 2 → `LEVEL` stays 2 and the toggle phase is undisturbed.
4. **Pause and resume:** pause 100 cycles after a toggle at level 1 (half-period 1000 cycles), wait 5000 cycles, resume → `LED` is constant while paused, and the next toggle comes 900 cycles after resume.
5. **Collision at terminal count:** assert `BTN_DN` in the exact terminal-count cycle at level 1 → `LED` does not toggle, `LEVEL`=0, and the next toggle is 2000 cycles later.
6. **Async reset mid-operation:** drop `RST` between clock edges at level 3 while paused → outputs return to `LED`=0, `LEVEL`=0, `RUN`=1 without waiting for a clock edge.
